// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern transmitter and the detector benches.
// Holds the transmitter FSM state type, the default pattern width and the length-field width helper.
package seq_pkg;

    typedef enum logic {
        SEQ_IDLE  = 1'b0,
        SEQ_SHIFT = 1'b1
    } seq_state_t;

    localparam int SEQ_WIDTH = 8;

    // The length field must hold 0..w inclusive, so it needs one more code than w.
    function automatic int seq_len_w(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/seq_pattern_tx.sv
// Serial bit-pattern transmitter: sends a captured pattern MSB-first on x, repeated in_rep+1 times.
// Back-to-back requests can be accepted on the last bit so that consecutive patterns have no gap.
module seq_pattern_tx
    import seq_pkg::*;
#(
    parameter int   WIDTH    = SEQ_WIDTH,
    parameter int   LEN_W    = seq_len_w(WIDTH),
    parameter int   REP_W    = 4,
    parameter logic IDLE_LVL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [LEN_W-1:0] in_len,
    input  logic [REP_W-1:0] in_rep,
    input  logic             abort,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic             done
);

    localparam int IDX_W = $clog2(WIDTH);

    seq_state_t       state, state_nxt;
    logic [WIDTH-1:0] pat, pat_nxt;
    logic [LEN_W-1:0] len, len_nxt;
    logic [LEN_W-1:0] idx, idx_nxt;
    logic [REP_W-1:0] rep_left, rep_left_nxt;
    logic             last_bit;
    logic             accept;

    assign last_bit = (state == SEQ_SHIFT) && (idx == '0) && (rep_left == '0);
    assign in_ready = (state == SEQ_IDLE) || (last_bit && !abort);
    assign accept   = in_valid && in_ready;

    // Serial outputs decode only registered state, so they never follow in_* within a cycle.
    assign x       = (state == SEQ_SHIFT) ? pat[idx[IDX_W-1:0]] : IDLE_LVL;
    assign x_valid = (state == SEQ_SHIFT);
    assign busy    = (state == SEQ_SHIFT);
    assign done    = last_bit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= SEQ_IDLE;
            pat      <= '0;
            len      <= '0;
            idx      <= '0;
            rep_left <= '0;
        end else begin
            state    <= state_nxt;
            pat      <= pat_nxt;
            len      <= len_nxt;
            idx      <= idx_nxt;
            rep_left <= rep_left_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        pat_nxt      = pat;
        len_nxt      = len;
        idx_nxt      = idx;
        rep_left_nxt = rep_left;

        if (state == SEQ_SHIFT) begin
            if (abort) begin
                state_nxt = SEQ_IDLE;
            end else if (idx != '0) begin
                idx_nxt = idx - LEN_W'(1);
            end else if (rep_left != '0) begin
                idx_nxt      = len - LEN_W'(1);
                rep_left_nxt = rep_left - REP_W'(1);
            end else begin
                state_nxt = SEQ_IDLE;
            end
        end

        // Accept is only possible in IDLE or on an un-aborted last bit, so it overrides the above.
        if (accept) begin
            pat_nxt      = in_data;
            len_nxt      = in_len;
            rep_left_nxt = in_rep;
            idx_nxt      = in_len - LEN_W'(1);
            state_nxt    = (in_len != '0) ? SEQ_SHIFT : SEQ_IDLE;
        end
    end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx with hand-computed bit streams and a small 101-detector model.
module tb_seq_pattern_tx;
    import seq_pkg::*;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [3:0] in_len;
    logic [3:0] in_rep;
    logic       abort;
    logic       x;
    logic       x_valid;
    logic       busy;
    logic       done;

    int compared;
    int mismatched;
    int zcount;
    logic [2:0] hist;

    seq_pattern_tx #(
        .WIDTH   (8),
        .LEN_W   (4),
        .REP_W   (4),
        .IDLE_LVL(1'b0)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data (in_data),
        .in_len  (in_len),
        .in_rep  (in_rep),
        .abort   (abort),
        .x       (x),
        .x_valid (x_valid),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        assert (!(in_valid && (in_len > 4'd8)))
            else $error("[TB] illegal in_len %0d > WIDTH", in_len);
    end

    // Reference 101 detector watching the same serial stream a paired detector would see.
    always @(negedge clk or negedge rst) begin
        if (!rst) begin
            hist <= 3'b000;
        end else if (x_valid) begin
            hist <= {hist[1:0], x};
            if ({hist[1:0], x} == 3'b101) zcount <= zcount + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] data, input logic [3:0] len, input logic [3:0] rep);
        in_valid = 1'b1;
        in_data  = data;
        in_len   = len;
        in_rep   = rep;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic expectBits(input logic [15:0] bits, input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            checkOutput({tag, " x"}, x, bits[n-1-k]);
            checkOutput({tag, " x_valid"}, x_valid, 1'b1);
            checkOutput({tag, " busy"}, busy, 1'b1);
            checkOutput({tag, " done"}, done, (k == n - 1));
        end
        @(negedge clk);
        checkOutput({tag, " idle x"}, x, 1'b0);
        checkOutput({tag, " idle x_valid"}, x_valid, 1'b0);
        checkOutput({tag, " idle busy"}, busy, 1'b0);
        checkOutput({tag, " idle done"}, done, 1'b0);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        zcount     = 0;
        rst        = 1'b0;
        in_valid   = 1'b0;
        in_data    = 8'h00;
        in_len     = 4'd0;
        in_rep     = 4'd0;
        abort      = 1'b0;

        #3;
        checkOutput("reset x", x, 1'b0);
        checkOutput("reset x_valid", x_valid, 1'b0);
        checkOutput("reset busy", busy, 1'b0);
        checkOutput("reset done", done, 1'b0);
        checkOutput("reset in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst = 1'b1;

        // Single 101 pattern.
        applyStimulus(8'h05, 4'd3, 4'd0);
        expectBits(16'b101, 3, "p101");
        checkOutput("p101 z count", zcount, 1);

        // Same pattern repeated three times, back-to-back.
        applyStimulus(8'h05, 4'd3, 4'd2);
        expectBits(16'b101101101, 9, "rep3");

        // Back-to-back patterns with in_valid held across the first transfer.
        in_valid = 1'b1;
        in_data  = 8'h02;
        in_len   = 4'd2;
        in_rep   = 4'd0;
        @(posedge clk);
        #1;
        in_data = 8'h01;
        @(negedge clk);
        checkOutput("b2b bit1 x", x, 1'b1);
        checkOutput("b2b bit1 in_ready", in_ready, 1'b0);
        checkOutput("b2b bit1 done", done, 1'b0);
        @(negedge clk);
        checkOutput("b2b bit2 x", x, 1'b0);
        checkOutput("b2b bit2 in_ready", in_ready, 1'b1);
        checkOutput("b2b bit2 done", done, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("b2b bit3 x", x, 1'b0);
        checkOutput("b2b bit3 x_valid", x_valid, 1'b1);
        checkOutput("b2b bit3 done", done, 1'b0);
        @(negedge clk);
        checkOutput("b2b bit4 x", x, 1'b1);
        checkOutput("b2b bit4 x_valid", x_valid, 1'b1);
        checkOutput("b2b bit4 done", done, 1'b1);
        @(negedge clk);
        checkOutput("b2b idle x_valid", x_valid, 1'b0);

        // Abort on bit 2 while offering another pattern, which must not be taken.
        applyStimulus(8'hAA, 4'd8, 4'd0);
        @(negedge clk);
        checkOutput("abort bit1 x", x, 1'b1);
        checkOutput("abort bit1 done", done, 1'b0);
        @(negedge clk);
        checkOutput("abort bit2 x", x, 1'b0);
        checkOutput("abort bit2 done", done, 1'b0);
        abort    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h0F;
        in_len   = 4'd4;
        #1;
        checkOutput("abort in_ready", in_ready, 1'b0);
        @(posedge clk);
        #1;
        abort    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("abort after x_valid", x_valid, 1'b0);
        checkOutput("abort after done", done, 1'b0);
        checkOutput("abort after busy", busy, 1'b0);
        checkOutput("abort after in_ready", in_ready, 1'b1);
        @(negedge clk);
        checkOutput("abort no accept x_valid", x_valid, 1'b0);

        // Asynchronous reset in the middle of a transfer.
        applyStimulus(8'hFF, 4'd8, 4'd0);
        @(negedge clk);
        checkOutput("rst bit1 x", x, 1'b1);
        @(negedge clk);
        checkOutput("rst bit2 x", x, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("rst async x", x, 1'b0);
        checkOutput("rst async busy", busy, 1'b0);
        checkOutput("rst async x_valid", x_valid, 1'b0);
        checkOutput("rst async in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        checkOutput("rst held x_valid", x_valid, 1'b0);
        applyStimulus(8'h05, 4'd3, 4'd0);
        expectBits(16'b101, 3, "post rst");

        // Zero-length request, then a one-bit pattern.
        applyStimulus(8'hFF, 4'd0, 4'd0);
        @(negedge clk);
        checkOutput("len0 x_valid", x_valid, 1'b0);
        checkOutput("len0 done", done, 1'b0);
        checkOutput("len0 busy", busy, 1'b0);
        checkOutput("len0 in_ready", in_ready, 1'b1);
        applyStimulus(8'h01, 4'd1, 4'd0);
        expectBits(16'b1, 1, "len1");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/seq_pattern_tx.md
# seq_pattern_tx

Serial bit-pattern transmitter: accepts a parallel pattern word with a length and a repeat count over a valid/ready handshake, then drives it one bit per clock onto a single serial line `x`, MSB-first. It is the stimulus source for the serial sequence detectors (e.g. the 101 detector). It replaces hand-written `x` sequences in benches, and it serves as the on-chip pattern source for detector self-test.

## Interface
- `WIDTH`, 8: maximum pattern length in bits (≥2).
- `LEN_W`, $clog2(WIDTH+1): width of the length field (derived).
- `REP_W`, 4: width of the repeat field.
- `IDLE_LVL`, 1'b0: level driven on `x` when no bit is being sent.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  request carries a pattern.
- `in_ready`  out  1  block can accept a pattern this cycle.
- `in_data`  in  WIDTH  pattern bits; only `in_data[in_len-1:0]` are used.
- `in_len`  in  LEN_W  number of bits to send, 0..WIDTH.
- `in_rep`  in  REP_W  extra repetitions; the pattern is sent `in_rep+1` times.
- `abort`  in  1  synchronous cancel of the current transfer.
- `x`  out  1  serial data, registered.
- `x_valid`  out  1  `x` carries a pattern bit this cycle.
- `busy`  out  1  a transfer is in progress.
- `done`  out  1  one-cycle pulse on the last bit of the last repetition.

## Operation
- FSM has two states, IDLE and SHIFT.
- Accept happens at a rising edge with `in_valid && in_ready`. `in_data`, `in_len` and `in_rep` are captured into registers `pat`, `len`, `rep_left`. Bit counter `idx = in_len-1`.
- IDLE → SHIFT on accept with `in_len != 0`.
- An accept with `in_len == 0` is consumed without sending any bits: no `x_valid`, no `done`, state stays IDLE.
- In SHIFT, `x = pat[idx]` and `x_valid = 1`.
  - When `idx != 0`: `idx--` at each edge.
  - When `idx == 0` and `rep_left != 0`: `idx = len-1`, `rep_left--`. Repetitions are back-to-back with no gap cycle.
  - When `idx == 0` and `rep_left == 0`: this is the last bit. `done = 1` during this cycle. The next state is IDLE, unless a new accept occurs on the same edge, in which case the FSM stays in SHIFT with the new pattern.
- `in_ready = (state == IDLE) || (last bit && !abort)`. This allows back-to-back patterns with zero idle cycles.
- `abort` high at an edge while in SHIFT: next state IDLE. No `done` is produced, `in_ready` is low that cycle, and no accept occurs. `abort` in IDLE is ignored.
- `busy = (state == SHIFT)`.
- Outputs `x`, `x_valid`, `busy` and `done` are registered or decoded from registered state only. None of them depends combinationally on `in_*`.

## Timing
- Reset (`rst` low, asynchronous):
  - state IDLE;
  - `x = IDLE_LVL`, `x_valid = 0`, `busy = 0`, `done = 0`, `in_ready = 1`;
  - `pat`, `len`, `idx` and `rep_left` are cleared.
- Reset assertion mid-transfer aborts immediately. There is no `done` and no further bits.
- Latency: the first bit is on `x` in the cycle after the accepting edge.
- Duration: a transfer occupies exactly `in_len*(in_rep+1)` consecutive `x_valid` cycles.
- Between transfers (IDLE), `x = IDLE_LVL` and `x_valid = 0`.
- Holding `in_data` after the accept has no effect; inputs are sampled only at the accepting edge.
- `in_len > WIDTH` is illegal. The bench flags it with an assertion; RTL behaviour is undefined.

## Structure
- Shared package `seq_pkg` holds:
  - the FSM state typedef (`SEQ_IDLE`, `SEQ_SHIFT`);
  - the `WIDTH` default;
  - the `LEN_W` derivation function.
- Single module with no sub-module. The `idx` / `rep_left` counter pair stays inline. `seq_pkg` is also used by the detector bench.
- Pairing bench: connect `seq_pattern_tx.x` to the detector's `x`. The detector's `z` is checked against a reference model that sees the same bits.

## Test plan
- Reset, then `in_data=8'h05`, `in_len=3`, `in_rep=0`:
  - `x = 1,0,1` on cycles 1–3 after the accept, with `x_valid=1`;
  - `done` high only on cycle 3;
  - `x=0`, `x_valid=0` on cycle 4;
  - the attached 101 detector asserts `z` once.
- `in_data=8'h05`, `in_len=3`, `in_rep=2`:
  - 9 contiguous bits `101101101`;
  - `done` only on bit 9;
  - `busy` high for exactly 9 cycles.
- Back-to-back patterns: hold `in_valid` with `8'h02`/len 2, then `8'h01`/len 2:
  - `x = 1,0,0,1` with no gap;
  - `in_ready` high on the first pattern's last bit;
  - two `done` pulses.
- `abort` asserted on bit 2 of `8'hAA`/len 8:
  - bits 1–2 sent (`1,0`), then `x_valid=0`;
  - no `done`;
  - `in_ready=1` next cycle.
- `rst` dropped asynchronously mid-bit on `8'hFF`/len 8:
  - `x=IDLE_LVL`, `busy=0`, `x_valid=0` immediately, before the next edge;
  - after release, a new accept works normally.
- `in_len=0` accept:
  - no `x_valid`, no `done`;
  - `in_ready` stays 1;
  - a following len-1 pattern `1` appears one cycle after its own accept.
